// File: rtl/pipe_ctrl_if.sv
// Bundle of stage hazard fields, data-memory handshake and pipeline control outputs.
// The pipeline datapath acts as master and pipe_ctrl as slave.
interface pipe_ctrl_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RADDR = 5,
    parameter int unsigned CNT_W = 16
);
    logic [RADDR-1:0] id_rs1;
    logic [RADDR-1:0] id_rs2;
    logic             id_use1;
    logic             id_use2;
    logic [RADDR-1:0] ex_rs1;
    logic [RADDR-1:0] ex_rs2;
    logic [RADDR-1:0] ex_wrreg;
    logic             ex_memread;
    logic             ex_regwrite;
    logic [RADDR-1:0] mem_wrreg;
    logic             mem_regwrite;
    logic             mem_req;
    logic             mem_ready;
    logic [RADDR-1:0] wb_wrreg;
    logic             wb_regwrite;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;

    logic [XLEN-1:0]  pc;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             stall_id;
    logic             bubble_ex;
    logic             flush;
    logic             hold_all;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use1, id_use2,
        output ex_rs1, ex_rs2, ex_wrreg, ex_memread, ex_regwrite,
        output mem_wrreg, mem_regwrite, mem_req, mem_ready,
        output wb_wrreg, wb_regwrite, redirect, redirect_pc,
        input  pc, fwd_a, fwd_b, stall_id, bubble_ex, flush, hold_all,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use1, id_use2,
        input  ex_rs1, ex_rs2, ex_wrreg, ex_memread, ex_regwrite,
        input  mem_wrreg, mem_regwrite, mem_req, mem_ready,
        input  wb_wrreg, wb_regwrite, redirect, redirect_pc,
        output pc, fwd_a, fwd_b, stall_id, bubble_ex, flush, hold_all,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard controller: PC sequencing, forwarding selects, load-use
// stall, redirect flush (deferred across memory waits) and stall/flush counters.
module pipe_ctrl #(
    parameter int unsigned    XLEN     = 32,
    parameter int unsigned    RADDR    = 5,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned    CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_ctrl_if.slave  bus
);

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic {RUN, MWAIT} state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pend_pc_q;
    logic             pend_q;
    logic [XLEN-1:0]  tgt;
    logic             hold;
    logic             redir_take;
    logic             stall;
    logic             load_use;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    function automatic logic [1:0] fwd_sel(
        input logic [RADDR-1:0] rs,
        input logic             mem_we,
        input logic [RADDR-1:0] mem_rd,
        input logic             wb_we,
        input logic [RADDR-1:0] wb_rd
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_we && (mem_rd != '0) && (mem_rd == rs))
            sel = FWD_MEM;
        else if (wb_we && (wb_rd != '0) && (wb_rd == rs))
            sel = FWD_WB;
        return sel;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Next state and all zero-latency control outputs; every output is forced low in reset.
    always_comb begin
        state_d       = state_q;
        hold          = 1'b0;
        redir_take    = 1'b0;
        stall         = 1'b0;
        tgt           = bus.redirect ? bus.redirect_pc : pend_pc_q;
        load_use      = bus.ex_memread && bus.ex_regwrite && (bus.ex_wrreg != '0) &&
                        ((bus.id_use1 && (bus.id_rs1 == bus.ex_wrreg)) ||
                         (bus.id_use2 && (bus.id_rs2 == bus.ex_wrreg)));
        bus.fwd_a     = FWD_RF;
        bus.fwd_b     = FWD_RF;

        case (state_q)
            RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    hold    = 1'b1;
                    state_d = MWAIT;
                end
            end
            MWAIT: begin
                if (bus.mem_ready) state_d = RUN;
                else               hold    = 1'b1;
            end
        endcase

        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            bus.fwd_a = fwd_sel(bus.ex_rs1, bus.mem_regwrite, bus.mem_wrreg,
                                bus.wb_regwrite, bus.wb_wrreg);
            bus.fwd_b = fwd_sel(bus.ex_rs2, bus.mem_regwrite, bus.mem_wrreg,
                                bus.wb_regwrite, bus.wb_wrreg);
            // A redirect held back by a memory wait wins the first free cycle.
            if (!hold) begin
                if (bus.redirect || pend_q) redir_take = 1'b1;
                else if (load_use)          stall      = 1'b1;
            end
        end

        if (hold || stall)  pc_d = pc_q;
        else if (redir_take) pc_d = {tgt[XLEN-1:2], 2'b00};
        else                 pc_d = pc_q + XLEN'(4);

        bus.hold_all  = hold;
        bus.flush     = redir_take;
        bus.stall_id  = stall;
        bus.bubble_ex = stall;
    end

    // PC, pending redirect and saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            pend_q      <= 1'b0;
            pend_pc_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (hold && bus.redirect) begin
                pend_q    <= 1'b1;
                pend_pc_q <= bus.redirect_pc;
            end else if (redir_take) begin
                pend_q    <= 1'b0;
            end
            if ((stall || hold) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (redir_take && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.pc        = pc_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a reference model pushes expected outputs per cycle,
// which are popped and compared against two instances (16-bit and 2-bit counters).
module tb_pipe_ctrl;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RADDR  = 5;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CNT_W2 = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.XLEN(XLEN), .RADDR(RADDR), .CNT_W(CNT_W))  b1();
    pipe_ctrl_if #(.XLEN(XLEN), .RADDR(RADDR), .CNT_W(CNT_W2)) b2();

    pipe_ctrl #(.XLEN(XLEN), .RADDR(RADDR), .RESET_PC('0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b1));
    pipe_ctrl #(.XLEN(XLEN), .RADDR(RADDR), .RESET_PC('0), .CNT_W(CNT_W2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2));

    assign b2.id_rs1       = b1.id_rs1;
    assign b2.id_rs2       = b1.id_rs2;
    assign b2.id_use1      = b1.id_use1;
    assign b2.id_use2      = b1.id_use2;
    assign b2.ex_rs1       = b1.ex_rs1;
    assign b2.ex_rs2       = b1.ex_rs2;
    assign b2.ex_wrreg     = b1.ex_wrreg;
    assign b2.ex_memread   = b1.ex_memread;
    assign b2.ex_regwrite  = b1.ex_regwrite;
    assign b2.mem_wrreg    = b1.mem_wrreg;
    assign b2.mem_regwrite = b1.mem_regwrite;
    assign b2.mem_req      = b1.mem_req;
    assign b2.mem_ready    = b1.mem_ready;
    assign b2.wb_wrreg     = b1.wb_wrreg;
    assign b2.wb_regwrite  = b1.wb_regwrite;
    assign b2.redirect     = b1.redirect;
    assign b2.redirect_pc  = b1.redirect_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        st;
        logic        fl;
        logic        hold;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [1:0]  sc2;
        logic [1:0]  fc2;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    logic        m_wait;
    logic        m_pend;
    logic [31:0] m_pc;
    logic [31:0] m_pend_pc;
    int          m_sc;
    int          m_fc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_wait    = 1'b0;
        m_pend    = 1'b0;
        m_pc      = 32'h0;
        m_pend_pc = 32'h0;
        m_sc      = 0;
        m_fc      = 0;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (b1.mem_regwrite && b1.mem_wrreg != 5'd0 && b1.mem_wrreg == rs) return 2'd1;
        if (b1.wb_regwrite && b1.wb_wrreg != 5'd0 && b1.wb_wrreg == rs)    return 2'd2;
        return 2'd0;
    endfunction

    function automatic exp_t model_comb();
        exp_t e;
        logic lu;
        e     = '0;
        e.pc  = m_pc;
        e.sc  = 16'((m_sc > 65535) ? 65535 : m_sc);
        e.fc  = 16'((m_fc > 65535) ? 65535 : m_fc);
        e.sc2 = 2'((m_sc > 3) ? 3 : m_sc);
        e.fc2 = 2'((m_fc > 3) ? 3 : m_fc);
        if (rst_n) begin
            e.fa   = model_fwd(b1.ex_rs1);
            e.fb   = model_fwd(b1.ex_rs2);
            e.hold = m_wait ? !b1.mem_ready : (b1.mem_req && !b1.mem_ready);
            lu = b1.ex_memread && b1.ex_regwrite && b1.ex_wrreg != 5'd0 &&
                 ((b1.id_use1 && b1.id_rs1 == b1.ex_wrreg) ||
                  (b1.id_use2 && b1.id_rs2 == b1.ex_wrreg));
            if (!e.hold) begin
                if (b1.redirect || m_pend) e.fl = 1'b1;
                else if (lu)               e.st = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic void model_update(input exp_t e);
        logic [31:0] tgt;
        tgt = b1.redirect ? b1.redirect_pc : m_pend_pc;
        if (e.hold && b1.redirect) begin
            m_pend    = 1'b1;
            m_pend_pc = b1.redirect_pc;
        end else if (e.fl) begin
            m_pend = 1'b0;
        end
        if (!(e.hold || e.st)) m_pc = e.fl ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
        m_wait = e.hold;
        if (e.hold || e.st) m_sc++;
        if (e.fl)           m_fc++;
    endfunction

    // One cycle: inputs were driven at the previous negedge.
    task automatic step();
        exp_t e;
        exp_t got;
        #1;
        e = model_comb();
        sb.push_back(e);
        got = sb.pop_front();
        check("pc",         64'(b1.pc),        64'(got.pc));
        check("fwd_a",      64'(b1.fwd_a),     64'(got.fa));
        check("fwd_b",      64'(b1.fwd_b),     64'(got.fb));
        check("stall_id",   64'(b1.stall_id),  64'(got.st));
        check("bubble_ex",  64'(b1.bubble_ex), 64'(got.st));
        check("flush",      64'(b1.flush),     64'(got.fl));
        check("hold_all",   64'(b1.hold_all),  64'(got.hold));
        check("stall_cnt",  64'(b1.stall_cnt), 64'(got.sc));
        check("flush_cnt",  64'(b1.flush_cnt), 64'(got.fc));
        check("hold_all2",  64'(b2.hold_all),  64'(got.hold));
        check("stall_cnt2", 64'(b2.stall_cnt), 64'(got.sc2));
        check("flush_cnt2", 64'(b2.flush_cnt), 64'(got.fc2));
        @(posedge clk);
        if (rst_n) model_update(e);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        b1.id_rs1 = '0; b1.id_rs2 = '0; b1.id_use1 = 1'b0; b1.id_use2 = 1'b0;
        b1.ex_rs1 = '0; b1.ex_rs2 = '0; b1.ex_wrreg = '0;
        b1.ex_memread = 1'b0; b1.ex_regwrite = 1'b0;
        b1.mem_wrreg = '0; b1.mem_regwrite = 1'b0; b1.mem_req = 1'b0; b1.mem_ready = 1'b0;
        b1.wb_wrreg = '0; b1.wb_regwrite = 1'b0;
        b1.redirect = 1'b0; b1.redirect_pc = '0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        b1.ex_memread = 1'b1; b1.ex_regwrite = 1'b1; b1.ex_wrreg = rd;
        b1.id_rs2 = 5'd3; b1.id_use2 = 1'b1;
    endtask

    initial begin
        logic [31:0] pc_ref;
        int          sc_ref;
        clear_inputs();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        b1.mem_req = 1'b1; b1.redirect = 1'b1;
        set_load_use(5'd3);
        step();
        clear_inputs();
        step();

        // Reset release with no hazards: pc 0,4,8,12,16
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("pc_seq", 64'(b1.pc), 64'(i * 4));
            step();
        end

        // Load-use on rs2, then the same with x0 as destination
        pc_ref = m_pc;
        set_load_use(5'd3);
        #1 check("lu_stall", 64'(b1.stall_id), 64'd1);
        step();
        check("lu_pc_held", 64'(b1.pc), 64'(pc_ref));
        set_load_use(5'd0);
        #1 check("lu_x0_nostall", 64'(b1.stall_id), 64'd0);
        step();
        clear_inputs();

        // Forwarding priority and x0 exclusion
        b1.mem_regwrite = 1'b1; b1.mem_wrreg = 5'd5;
        b1.wb_regwrite = 1'b1;  b1.wb_wrreg = 5'd5;
        b1.ex_rs1 = 5'd5; b1.ex_rs2 = 5'd5;
        #1 check("fwd_mem", 64'(b1.fwd_a), 64'd1);
        step();
        b1.mem_regwrite = 1'b0;
        #1 check("fwd_wb", 64'(b1.fwd_a), 64'd2);
        step();
        b1.mem_wrreg = 5'd0; b1.wb_wrreg = 5'd0; b1.ex_rs1 = 5'd0;
        b1.mem_regwrite = 1'b1;
        step();
        b1.mem_regwrite = 1'b0;
        step();
        clear_inputs();

        // Redirect beats a simultaneous load-use hazard
        b1.redirect = 1'b1; b1.redirect_pc = 32'h103;
        set_load_use(5'd3);
        #1 check("redir_flush", 64'(b1.flush), 64'd1);
        check("redir_nostall", 64'(b1.stall_id), 64'd0);
        step();
        check("redir_pc", 64'(b1.pc), 64'h100);
        clear_inputs();

        // Memory wait with a redirect arriving mid-wait
        pc_ref = m_pc;
        sc_ref = m_sc;
        b1.mem_req = 1'b1; b1.mem_ready = 1'b0;
        #1 check("mw_hold1", 64'(b1.hold_all), 64'd1);
        step();
        b1.redirect = 1'b1; b1.redirect_pc = 32'h40;
        step();
        b1.redirect = 1'b0; b1.redirect_pc = 32'h0;
        step();
        check("mw_pc_frozen", 64'(b1.pc), 64'(pc_ref));
        b1.mem_ready = 1'b1;
        #1 check("mw_flush", 64'(b1.flush), 64'd1);
        check("mw_release", 64'(b1.hold_all), 64'd0);
        step();
        check("mw_pc_target", 64'(b1.pc), 64'h40);
        check("mw_stall_cnt", 64'(b1.stall_cnt), 64'(sc_ref + 3));
        clear_inputs();

        // Five stall cycles: the 2-bit counter saturates
        set_load_use(5'd3);
        for (int i = 0; i < 5; i++) step();
        check("sat_cnt2", 64'(b2.stall_cnt), 64'd3);
        clear_inputs();

        // Randomised traffic over small register indices
        for (int i = 0; i < 400; i++) begin
            b1.id_rs1 = 5'($urandom_range(0, 3)); b1.id_rs2 = 5'($urandom_range(0, 3));
            b1.id_use1 = 1'($urandom_range(0, 1)); b1.id_use2 = 1'($urandom_range(0, 1));
            b1.ex_rs1 = 5'($urandom_range(0, 3)); b1.ex_rs2 = 5'($urandom_range(0, 3));
            b1.ex_wrreg = 5'($urandom_range(0, 3));
            b1.ex_memread = 1'($urandom_range(0, 1)); b1.ex_regwrite = 1'($urandom_range(0, 1));
            b1.mem_wrreg = 5'($urandom_range(0, 3)); b1.mem_regwrite = 1'($urandom_range(0, 1));
            b1.wb_wrreg = 5'($urandom_range(0, 3));  b1.wb_regwrite = 1'($urandom_range(0, 1));
            b1.mem_req = ($urandom_range(0, 3) == 0);
            b1.mem_ready = 1'($urandom_range(0, 1));
            b1.redirect = ($urandom_range(0, 5) == 0);
            b1.redirect_pc = $urandom();
            step();
        end
        clear_inputs();
        step();

        // Asynchronous reset during a wait with a pending redirect
        b1.mem_req = 1'b1; b1.mem_ready = 1'b0;
        step();
        b1.redirect = 1'b1; b1.redirect_pc = 32'h80;
        step();
        b1.redirect = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("rst_hold", 64'(b1.hold_all), 64'd0);
        check("rst_pc", 64'(b1.pc), 64'h0);
        check("rst_scnt", 64'(b1.stall_cnt), 64'd0);
        check("rst_fcnt", 64'(b1.flush_cnt), 64'd0);
        step();
        clear_inputs();
        rst_n = 1'b1;
        step();
        check("rst_exit_pc", 64'(b1.pc), 64'h4);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
